// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one pipelined adder among four requesters.
// Result tags ride a pipeline alongside the adder and route each result back to its requester.
module adder #(
  parameter int BIT = 3
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic [BIT-1:0] A,
  input  logic [BIT-1:0] B,
  input  logic           addsub,
  output logic [BIT-1:0] SUM,
  output logic           cout
);
  logic [BIT-1:0] a0, b0;
  logic [BIT:0]   s1, s2, s3;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      a0 <= '0;
      b0 <= '0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      a0 <= A;
      b0 <= addsub ? ~B + BIT'(1) : B;
      s1 <= {1'b0, a0} + {1'b0, b0};
      s2 <= s1;
      s3 <= s2;
    end
  assign {cout, SUM} = s3;
endmodule

module adder_arbiter #(
  parameter int BIT = 3
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [3:0]       req_valid,
  output logic [3:0]       req_ready,
  input  logic [4*BIT-1:0] req_a,
  input  logic [4*BIT-1:0] req_b,
  input  logic [3:0]       req_sub,
  output logic [3:0]       rsp_valid,
  output logic [BIT-1:0]   rsp_sum,
  output logic             rsp_cout,
  output logic [2:0]       inflight
);
  logic [1:0]      ptr, gid, idx;
  logic            gnt, iv, isub;
  logic [1:0]      iid;
  logic [BIT-1:0]  ia, ib;
  logic [3:0]      tv;
  logic [3:0][1:0] tid;
  always_comb begin
    gnt = 1'b0;
    gid = ptr;
    idx = ptr;
    for (int o = 0; o < 4; o++) begin
      idx = ptr + 2'(o);
      if (!gnt && req_valid[idx]) begin
        gnt = 1'b1;
        gid = idx;
      end
    end
  end
  assign req_ready = gnt ? 4'b0001 << gid : 4'b0000;
  // inflight drops on the edge that raises rsp_valid, keeping it within 0..4 at full rate
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      ptr      <= '0;
      iv       <= 1'b0;
      iid      <= '0;
      ia       <= '0;
      ib       <= '0;
      isub     <= 1'b0;
      tv       <= '0;
      tid      <= '0;
      inflight <= '0;
    end else begin
      ptr <= gnt ? gid + 2'd1 : ptr;
      iv  <= gnt;
      iid <= gid;
      if (gnt) begin
        ia   <= req_a[gid*BIT +: BIT];
        ib   <= req_b[gid*BIT +: BIT];
        isub <= req_sub[gid];
      end
      tv       <= {tv[2:0], iv};
      tid      <= {tid[2:0], iid};
      inflight <= inflight + 3'(gnt) - 3'(tv[2]);
    end
  assign rsp_valid = tv[3] ? 4'b0001 << tid[3] : 4'b0000;
  adder #(.BIT(BIT)) u_adder (
    .clk   (clk),
    .nrst  (nrst),
    .A     (ia),
    .B     (ib),
    .addsub(isub),
    .SUM   (rsp_sum),
    .cout  (rsp_cout)
  );
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and random stimulus checked against a transaction-level model.
module tb_adder_arbiter;
  localparam int BIT = 3;
  localparam int M = 1 << BIT;
  logic             clk = 1'b0;
  logic             nrst;
  logic [3:0]       req_valid, req_ready, req_sub, rsp_valid;
  logic [4*BIT-1:0] req_a, req_b;
  logic [BIT-1:0]   rsp_sum;
  logic             rsp_cout;
  logic [2:0]       inflight;
  typedef struct {int due; int id; int sum; int cout;} exp_t;
  exp_t q[$];
  int vectors = 0, errs = 0, cyc = 0, ptr = 0;

  adder_arbiter #(.BIT(BIT)) dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .rsp_valid(rsp_valid),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .inflight(inflight)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model_grant(input logic [3:0] v);
    for (int o = 0; o < 4; o++)
      if (v[(ptr + o) % 4]) return (ptr + o) % 4;
    return -1;
  endfunction

  task automatic step(input logic [3:0] v, input logic [4*BIT-1:0] a, input logic [4*BIT-1:0] b,
                      input logic [3:0] s);
    int g, ai, bi, sm;
    exp_t e;
    @(negedge clk);
    req_valid = v; req_a = a; req_b = b; req_sub = s;
    #1;
    g = model_grant(v);
    chk("req_ready", 32'(req_ready), g < 0 ? 32'd0 : 32'd1 << g);
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp_valid", 32'(rsp_valid), 32'd1 << q[0].id);
      chk("rsp_sum", 32'(rsp_sum), 32'(q[0].sum));
      chk("rsp_cout", 32'(rsp_cout), 32'(q[0].cout));
      void'(q.pop_front());
    end else chk("rsp_idle", 32'(rsp_valid), 32'd0);
    chk("inflight", 32'(inflight), 32'(q.size()));
    assert (inflight <= 3'd4) else begin
      errs++;
      $error("FAIL inflight_bound: observed %0d expected <= 4", inflight);
    end
    if (g >= 0) begin
      ai = int'(a[g*BIT +: BIT]);
      bi = int'(b[g*BIT +: BIT]);
      sm = ai + (s[g] ? (M - bi) % M : bi);
      e.due = cyc + 5; e.id = g; e.sum = sm % M; e.cout = (sm >= M) ? 1 : 0;
      q.push_back(e);
      ptr = (g + 1) % 4;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic op(input int i, input int a, input int b, input logic s);
    logic [4*BIT-1:0] pa, pb;
    pa = 12'($urandom); pb = 12'($urandom);
    pa[i*BIT +: BIT] = BIT'(a);
    pb[i*BIT +: BIT] = BIT'(b);
    step(4'b0001 << i, pa, pb, s ? 4'b1111 : 4'b0000);
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'b0000, 12'($urandom), 12'($urandom), 4'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0; req_valid = 4'b1010;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_sum", 32'(rsp_sum), 32'd0);
    chk("rst_cout", 32'(rsp_cout), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'h2);
    q.delete();
    ptr = 0;
    @(negedge clk);
    nrst = 1'b1; req_valid = 4'b0000;
  endtask

  initial begin
    nrst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0;
    do_reset();
    repeat (8) step(4'b1111, 12'($urandom), 12'($urandom), 4'($urandom));
    idle(6);
    op(2, 3, 2, 1'b0);
    op(2, 7, 1, 1'b0);
    idle(5);
    op(1, 5, 3, 1'b1);
    op(3, 2, 3, 1'b1);
    op(0, 4, 0, 1'b1);
    idle(5);
    do_reset();
    repeat (5) step(4'b1010, 12'($urandom), 12'($urandom), 4'($urandom));
    idle(5);
    op(0, 1, 1, 1'b0);
    op(1, 6, 7, 1'b0);
    op(3, 0, 5, 1'b1);
    idle(1);
    do_reset();
    idle(6);
    op(1, 6, 2, 1'b0);
    idle(5);
    repeat (4) begin
      op(0, int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)), 1'($urandom));
      idle(1);
    end
    idle(5);
    repeat (300) step(4'($urandom), 12'($urandom), 12'($urandom), 4'($urandom));
    idle(6);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin scheduler that shares one pipelined `adder` instance between four requesters. It accepts at most one add/subtract operation per cycle and tags every issued operation with its requester ID. It tracks the tag through the adder pipeline and routes the SUM/cout result back to the originating requester as a one-cycle response pulse. It sits between client blocks and the arithmetic datapath; clients never drive `adder` directly.

## Interface
- `BIT`, 3, operand and result width; passed unchanged to the internal `adder`.
- `clk` in 1 — single clock, all state updates on rising edge.
- `nrst` in 1 — asynchronous, active-low reset.
- `req_valid` in 4 — bit i: requester i presents an operation.
- `req_ready` out 4 — bit i: requester i granted this cycle (combinational, one-hot or zero).
- `req_a` in 4*BIT — operand A; requester i on bits [i*BIT +: BIT].
- `req_b` in 4*BIT — operand B, same packing.
- `req_sub` in 4 — bit i: 0 = add, 1 = subtract for requester i.
- `rsp_valid` out 4 — one-hot pulse: result for requester i is on `rsp_sum`/`rsp_cout`.
- `rsp_sum` out BIT — result, shared by all requesters.
- `rsp_cout` out 1 — carry-out, shared.
- `inflight` out 3 — number of accepted operations not yet responded (0..4).

## Operation
- Transfer on requester i when `req_valid[i] & req_ready[i]` at a rising edge; no other event consumes a request.
- Arbitration:
  - Round-robin pointer `ptr` (2 bits, reset 0).
  - Grant goes to the first requester with `req_valid` set, scanning ptr, ptr+1, … mod 4.
  - After a grant to i, `ptr` ← (i+1) mod 4. With no grant, `ptr` holds.
- `req_ready` depends only on `req_valid` and `ptr`, never on `req_a/req_b/req_sub`. At most one bit is set. All zero when `req_valid` = 0.
- No backpressure on responses: clients must accept `rsp_valid` unconditionally. Throughput is one operation per cycle, sustained.
- Issue register, loaded every edge:
  - {valid, id, a, b, sub} from the granted requester.
  - valid = 0 on cycles with no grant; a/b/sub then hold their previous value.
  - Its a/b/sub feed the `adder` A/B/addsub ports directly.
- Tag pipeline: 4-stage shift register of {valid, id}, fed from the issue register and advancing every cycle. Stage 4 aligns with the adder `SUM`/`cout` outputs.
- Response outputs:
  - `rsp_valid[id]` = stage-4 valid.
  - `rsp_sum` = adder `SUM`; `rsp_cout` = adder `cout`.
  - `rsp_sum`/`rsp_cout` are don't-care when `rsp_valid` = 0.
- Arithmetic is defined by the adder:
  - add: {cout, sum} = A + B.
  - sub: B is replaced by (~B+1) mod 2^BIT, then {cout, sum} = A + that value. Example: sub with B=0 gives cout=0.
- `inflight` counter:
  - +1 on a transfer, −1 on any `rsp_valid`; both in one cycle → unchanged.
  - Never exceeds 4 and never underflows; an assertion in the bench checks both.

## Timing
- Reset (nrst low, asynchronous) clears:
  - `ptr`, the issue-register valid, all tag valids, and `inflight`.
  - The internal adder clears via the same `nrst`.
- Output values in reset:
  - `rsp_valid` = 0, `rsp_sum` = 0, `rsp_cout` = 0, `inflight` = 0.
  - `req_ready` follows `req_valid` with `ptr` = 0.
- Latency: a transfer at edge k drives `rsp_valid` high for exactly the cycle between edges k+4 and k+5.
  - Edge k loads the issue register.
  - Edge k+1 loads adder stage 0.
  - Edge k+4 registers the adder output.
- Responses return in issue order. Back-to-back transfers produce back-to-back responses with no gaps.
- Reset asserted mid-operation: every in-flight operation is discarded with no response. First legal transfer is at the first edge after `nrst` rises.
- Simultaneous transfer and response in one cycle: both take effect. A requester may be granted in the same cycle it receives a response.
- Bubble cycles still clock garbage through the adder; the tag valid gates them, so no spurious `rsp_valid`.

## Test plan
- Reset, then all `req_valid`=1 held for 8 cycles → grants in order 0,1,2,3,0,1,2,3. `rsp_valid` one-hot in the same order starting 4 cycles after the first grant. `inflight` ramps 1,2,3,4 and holds at 4.
- Requester 2 only, BIT=3, add A=3 B=2 → `req_ready`=0100. Four cycles later `rsp_valid`=0100, `rsp_sum`=5, `rsp_cout`=0. A=7 B=1 → sum 0, cout 1.
- Subtract: A=5 B=3 sub=1 → sum 2, cout 1. A=2 B=3 sub=1 → sum 7, cout 0. A=4 B=0 sub=1 → sum 4, cout 0.
- Requesters 1 and 3 valid, `ptr`=0 → grant 1, then 3, then 1; requester 3 is never starved two cycles in a row.
- Three transfers issued, `nrst` pulsed low for 1 cycle mid-flight → no `rsp_valid` ever appears for them. `inflight`=0. A new request after reset returns a correct result with 4-cycle latency.
- Alternate valid/idle cycles on requester 0 → `rsp_valid` pulses only 4 cycles after each transfer; none during bubbles.
